// File: rtl/spec_vram_writer.sv
// CPU write port into the shared video RAM: decodes the video window, tags pixel
// bytes with the colour register, and queues them until the video reader is idle.
module spec_vram_writer #(
  parameter logic [15:0] VBASE = 16'h9000,
  parameter logic [15:0] VSIZE = 16'h3000,
  parameter int          DEPTH = 4
) (
  input  logic        clkVid,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic        color_wr,
  input  logic        rdvid,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_wait,
  output logic [2:0]  color,
  output logic        ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [16:0] WIN_END = {1'b0, VBASE} + {1'b0, VSIZE};

  // Entry layout: {addr[13:0], colour[2:0], pixels[7:0]}
  logic [24:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;

  logic [13:0] mem_addr_reg;
  logic [15:0] mem_data_reg;
  logic        mem_we_reg;
  logic        cpu_wait_reg;
  logic [2:0]  color_reg;
  logic        ovf_reg;

  logic        hit;
  logic [15:0] offset;
  logic [13:0] entry_addr;
  logic [24:0] entry;
  logic [24:0] head;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;

  // 17-bit compare so a window touching the top of the address space cannot wrap
  assign hit        = (cpu_addr >= VBASE) && ({1'b0, cpu_addr} < WIN_END);
  assign offset     = cpu_addr - VBASE;
  assign entry_addr = {offset[13:8] + 6'd16, offset[7:0]};
  assign entry      = {entry_addr, color_reg, cpu_data};
  assign head       = fifo_mem[rd_ptr_reg];

  assign full       = (level_reg == FULL_LVL);
  assign pop        = (level_reg != '0) && !rdvid;
  assign push_req   = cpu_wr && hit;
  assign push       = push_req && (!full || pop);
  assign level_next = level_reg + LW'(push) - LW'(pop);

  always_ff @(posedge clkVid) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clkVid or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_we_reg   <= 1'b0;
      cpu_wait_reg <= 1'b0;
      color_reg    <= 3'b111;
      ovf_reg      <= 1'b0;
    end else begin
      level_reg    <= level_next;
      cpu_wait_reg <= (level_next == FULL_LVL);
      mem_we_reg   <= pop;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        mem_addr_reg <= head[24:11];
        mem_data_reg <= {5'b0, head[10:0]};
      end
      if (push_req && !push)
        ovf_reg <= 1'b1;
      if (color_wr)
        color_reg <= cpu_data[2:0];
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign mem_we   = mem_we_reg;
  assign cpu_wait = cpu_wait_reg;
  assign color    = color_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_spec_vram_writer.sv
// Directed self-checking bench for spec_vram_writer.
module tb_spec_vram_writer;

  logic        clkVid = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        color_wr;
  logic        rdvid;
  logic [13:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_wait;
  logic [2:0]  color;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  spec_vram_writer dut (
    .clkVid   (clkVid),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_wr   (cpu_wr),
    .color_wr (color_wr),
    .rdvid    (rdvid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .cpu_wait (cpu_wait),
    .color    (color),
    .ovf      (ovf)
  );

  always #5 clkVid = ~clkVid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkVid);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    $display("write addr=%h data=%h rdvid=%0b", a, d, rdvid);
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic expect_we(input string tag, input logic [13:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_data), 32'(d));
  endtask

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_data = '0; cpu_wr = 0; color_wr = 0; rdvid = 0;
    #1;
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_data", 32'(mem_data), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_wait", 32'(cpu_wait), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_color", 32'(color), 32'h7);
    step(); step();
    reset = 1'b0;
    step();

    // Basic write with colour 5
    color_wr = 1'b1; cpu_data = 8'h05;
    step();
    color_wr = 1'b0;
    chk("color5", 32'(color), 32'h5);
    wr(16'h9000, 8'hA5);
    chk("lat_we0", 32'(mem_we), 32'h0);
    step();
    expect_we("basic", 14'h1000, 16'h05A5);
    step();
    chk("basic_pulse_end", 32'(mem_we), 32'h0);
    chk("basic_hold", 32'(mem_addr), 32'h1000);

    // Window edges
    wr(16'hBFFF, 8'h3C);
    step();
    expect_we("top", 14'h3FFF, 16'h053C);
    step();
    wr(16'h8FFF, 8'h11);
    chk("below_we", 32'(mem_we), 32'h0);
    wr(16'hC000, 8'h22);
    chk("above_we0", 32'(mem_we), 32'h0);
    step();
    chk("above_we1", 32'(mem_we), 32'h0);
    step();
    chk("above_we2", 32'(mem_we), 32'h0);
    chk("edge_ovf", 32'(ovf), 32'h0);
    chk("edge_wait", 32'(cpu_wait), 32'h0);

    // Colour register change in the same cycle as a write
    reset = 1'b1;
    #1;
    chk("rst2_color", 32'(color), 32'h7);
    step();
    reset = 1'b0;
    color_wr = 1'b1;
    wr(16'h9101, 8'h02);
    color_wr = 1'b0;
    chk("color2", 32'(color), 32'h2);
    wr(16'h9102, 8'h81);
    expect_we("samecyc_old", 14'h1101, 16'h0702);
    step();
    expect_we("samecyc_new", 14'h1102, 16'h0281);
    step();
    chk("samecyc_end", 32'(mem_we), 32'h0);

    // Arbitration: rdvid high blocks draining
    rdvid = 1'b1;
    wr(16'h9200, 8'h11);
    chk("arb_we_p0", 32'(mem_we), 32'h0);
    wr(16'h9201, 8'h22);
    chk("arb_we_p1", 32'(mem_we), 32'h0);
    wr(16'h9202, 8'h33);
    chk("arb_we_p2", 32'(mem_we), 32'h0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("arb_we_hold", 32'(mem_we), 32'h0);
    end
    chk("arb_wait", 32'(cpu_wait), 32'h0);
    rdvid = 1'b0;
    step();
    expect_we("arb0", 14'h1200, 16'h0211);
    step();
    expect_we("arb1", 14'h1201, 16'h0222);
    step();
    expect_we("arb2", 14'h1202, 16'h0233);
    step();
    chk("arb_end", 32'(mem_we), 32'h0);

    // Full FIFO and overflow
    rdvid = 1'b1;
    wr(16'h9300, 8'h40);
    wr(16'h9301, 8'h41);
    wr(16'h9302, 8'h42);
    chk("full_wait3", 32'(cpu_wait), 32'h0);
    wr(16'h9303, 8'h43);
    chk("full_wait4", 32'(cpu_wait), 32'h1);
    chk("full_ovf_pre", 32'(ovf), 32'h0);
    wr(16'h9304, 8'h44);
    chk("full_ovf", 32'(ovf), 32'h1);
    chk("full_wait5", 32'(cpu_wait), 32'h1);
    rdvid = 1'b0;
    step();
    expect_we("full0", 14'h1300, 16'h0240);
    chk("full_wait_rel", 32'(cpu_wait), 32'h0);
    step();
    expect_we("full1", 14'h1301, 16'h0241);
    step();
    expect_we("full2", 14'h1302, 16'h0242);
    step();
    expect_we("full3", 14'h1303, 16'h0243);
    step();
    chk("full_no5th", 32'(mem_we), 32'h0);
    chk("ovf_sticky", 32'(ovf), 32'h1);

    // Reset with writes queued
    rdvid = 1'b1;
    wr(16'h9400, 8'h55);
    wr(16'h9401, 8'h66);
    wr(16'h9402, 8'h77);
    rdvid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    chk("midrst_color", 32'(color), 32'h7);
    chk("midrst_wait", 32'(cpu_wait), 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_no_issue", 32'(mem_we), 32'h0);
    end
    chk("midrst_color_end", 32'(color), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
